btb_upd_sched: RTL and testbench
================================

# btb_upd_sched

Update scheduler for the branch target buffer. It collects BTB training updates from two branch-resolution pipes and single-entry invalidations from the commit stage. It also runs full-table clear sequences, then serializes everything onto the BTB's single correct/flush port. It guarantees that the BTB never sees a correct and a flush to the same index in the same cycle.

## Interface
- IDX_BITS, default `` `BTB_BITSi ``: BTB index width; index = addr[IDX_BITS+1:2].
- DEPTH, default 4: update FIFO entries (power of two, ≥2).
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- upd0_valid_i / upd1_valid_i  in  1  update request, pipe 0 (older) / pipe 1 (younger).
- upd0_ready_o / upd1_ready_o  out  1  request accepted when valid&ready at posedge.
- updN_addr_i  in  32  branch PC.
- updN_target_i  in  32  branch target.
- updN_flags_i  in  3  {uncondition, link, return}.
- fl_valid_i  in  1  single-entry invalidate request.
- fl_ready_o  out  1  invalidate slot free.
- fl_addr_i  in  32  PC to invalidate.
- clr_req_i  in  1  start a full-table clear (sampled in IDLE only).
- clr_busy_o  out  1  clear sequence in progress.
- corr_valid_o, corr_addr_o[31:0], corr_uncondition_flag_o, corr_link_flag_o, corr_return_flag_o, corr_branch_addr_o[31:0]  out  BTB correct port.
- corr_fllush_valid_o, corr_fllush_addr_o[31:0]  out  BTB flush port.

## Operation
- States: IDLE, CLEAR. Reset → IDLE, FIFO empty, flush slot empty, clear counter 0.
- Ready: upd0_ready_o = IDLE && free≥1; upd1_ready_o = IDLE && free≥2 (valid-independent). fl_ready_o = IDLE && slot empty.
- Same-cycle accept order: upd0 enqueued before upd1.
- IDLE issue, every cycle:
  - Flush slot occupied → drive flush with its address, empty the slot.
  - FIFO non-empty → drive head as correct and pop. Exception: head index == index being flushed this cycle → head held, no correct this cycle.
  - Both are issued together when indices differ.
- A slot write and a slot issue at the same edge are legal: issue the old entry, load the new one. A FIFO push and pop at the same edge are legal, including when full with upd0 blocked.
- clr_req_i high in IDLE → CLEAR at that edge:
  - FIFO and flush slot are discarded.
  - Each CLEAR cycle issues flush for index cnt, corr_fllush_addr_o = {zeros, cnt, 2'b00}, cnt++.
  - After issuing index 2^IDX_BITS−1 → IDLE, cnt←0.
  - No correct issued during CLEAR. clr_req_i in CLEAR is ignored.
- Non-valid outputs hold their last values. Valids deassert when nothing is issued.

## Timing
- All corr_* outputs are registered. All outputs are 0 after reset.
- Request accepted at edge k → output visible after edge k+1, absent backlog or conflict.
- Throughput: one correct plus one flush per cycle.
- Clear: clr_req_i sampled at edge k → flush index i visible after edge k+1+i. State returns to IDLE at edge k+2^IDX_BITS. clr_busy_o = (state==CLEAR), high for 2^IDX_BITS cycles.
- Reset mid-CLEAR aborts the clear. Outputs are 0 the next cycle.
- A correct for index X and a flush for index X are never issued in the same cycle.

## Structure
- Shared header cpu.vh: `` `BTB_BITSi ``, new `` `BTB_UPDQ_DEPTH ``, state encodings `` `BTBS_IDLE `` / `` `BTBS_CLEAR ``.
- Sub-module btb_upd_fifo: 2-write/1-read FIFO, 67-bit entries {addr, target, flags}, exposing count.
- Top level holds the FSM, flush slot, clear counter, conflict compare and output registers.

## Test plan
- Single update: upd0 addr 0x1C, target 0x400, flags 3'b100 at edge 0 → after edge 1, corr_valid_o=1 with those values for one cycle.
- Dual accept, IDX_BITS=4, DEPTH=4: upd0 0x10 and upd1 0x20 at the same edge → corrects 0x10 then 0x20 on consecutive cycles. With 3 entries queued: upd0_ready=1, upd1_ready=0.
- Conflict: flush 0x44 and FIFO head 0x84 (index 1 both) in the same cycle → flush only. The correct 0x84 is issued the following cycle.
- No conflict: flush 0x44 and head 0x48 → both valid in the same cycle.
- Clear with IDX_BITS=4: clr_req at edge 0 with 2 updates queued → flush addrs 0x0, 0x4 … 0x3C on 16 consecutive cycles. clr_busy high for 16 cycles. Queued updates are never issued. Ready signals are 0 throughout.
- Reset asserted during clear at index 5 → next cycle all outputs 0, IDLE, ready signals high.

Source files
------------

// File: rtl/btb_upd_sched_pkg.sv
// Shared types and defaults for the BTB update scheduler.
// Entry layout, FSM state encoding and an index-compare helper.
package btb_upd_sched_pkg;

  localparam int BTB_BITS       = 4;
  localparam int BTB_UPDQ_DEPTH = 4;

  typedef enum logic {
    BTBS_IDLE  = 1'b0,
    BTBS_CLEAR = 1'b1
  } btb_state_t;

  // flags = {uncondition, link, return}
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] target;
    logic [2:0]  flags;
  } upd_entry_t;

  function automatic logic idx_match(input logic [31:0] a, input logic [31:0] b,
                                     input int unsigned idx_bits);
    logic [31:0] mask;
    mask = ((32'd1 << idx_bits) - 32'd1) << 2;
    return ((a ^ b) & mask) == 32'd0;
  endfunction

endpackage

// File: rtl/btb_upd_sched_if.sv
// Request, invalidate, clear and BTB-side signals of the update scheduler.
// slave is the scheduler's view, master the requester/BTB-side view.
interface btb_upd_sched_if;
  logic        upd0_valid, upd0_ready;
  logic [31:0] upd0_addr, upd0_target;
  logic [2:0]  upd0_flags;
  logic        upd1_valid, upd1_ready;
  logic [31:0] upd1_addr, upd1_target;
  logic [2:0]  upd1_flags;
  logic        fl_valid, fl_ready;
  logic [31:0] fl_addr;
  logic        clr_req, clr_busy;
  logic        corr_valid;
  logic [31:0] corr_addr, corr_branch_addr;
  logic        corr_uncondition_flag, corr_link_flag, corr_return_flag;
  logic        corr_fllush_valid;
  logic [31:0] corr_fllush_addr;

  modport slave (
    input  upd0_valid, upd0_addr, upd0_target, upd0_flags,
    input  upd1_valid, upd1_addr, upd1_target, upd1_flags,
    input  fl_valid, fl_addr, clr_req,
    output upd0_ready, upd1_ready, fl_ready, clr_busy,
    output corr_valid, corr_addr, corr_branch_addr,
    output corr_uncondition_flag, corr_link_flag, corr_return_flag,
    output corr_fllush_valid, corr_fllush_addr
  );

  modport master (
    output upd0_valid, upd0_addr, upd0_target, upd0_flags,
    output upd1_valid, upd1_addr, upd1_target, upd1_flags,
    output fl_valid, fl_addr, clr_req,
    input  upd0_ready, upd1_ready, fl_ready, clr_busy,
    input  corr_valid, corr_addr, corr_branch_addr,
    input  corr_uncondition_flag, corr_link_flag, corr_return_flag,
    input  corr_fllush_valid, corr_fllush_addr
  );
endinterface

// File: rtl/btb_upd_sched_fifo.sv
// Two-write / one-read update FIFO; write port 0 lands ahead of port 1.
// Caller guarantees no overflow/underflow through its ready/pop logic.
module btb_upd_fifo
  import btb_upd_sched_pkg::*;
#(
  parameter int DEPTH = BTB_UPDQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   wr0_en,
  input  upd_entry_t             wr0_data,
  input  logic                   wr1_en,
  input  upd_entry_t             wr1_data,
  input  logic                   rd_en,
  output upd_entry_t             head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  upd_entry_t    mem [DEPTH];
  logic [PW-1:0] wptr, rptr, wptr1;

  assign wptr1 = wptr + PW'(wr0_en);
  assign head  = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr0_en) mem[wptr]  <= wr0_data;
    if (wr1_en) mem[wptr1] <= wr1_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PW'(wr0_en) + PW'(wr1_en);
      rptr  <= rptr + PW'(rd_en);
      count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end
endmodule

// File: rtl/btb_upd_sched.sv
// Serializes BTB training updates, single invalidates and full clears onto
// the BTB correct/flush port, never correcting and flushing one index together.
//
// state | meaning
// IDLE  | accept requests; issue flush slot and FIFO head each cycle
// CLEAR | flush index cnt each cycle; requests not accepted
module btb_upd_sched
  import btb_upd_sched_pkg::*;
#(
  parameter int IDX_BITS = BTB_BITS,
  parameter int DEPTH    = BTB_UPDQ_DEPTH
) (
  input logic             clk,
  input logic             rst,
  btb_upd_sched_if.slave  bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  btb_state_t          state;
  logic                slot_vld;
  logic [31:0]         slot_addr;
  logic [IDX_BITS-1:0] cnt;
  logic [CW-1:0]       count, free;
  upd_entry_t          head, in0, in1;
  logic                idle, go_clear, acc0, acc1, acc_fl, conflict, issue_corr;

  assign idle     = (state == BTBS_IDLE);
  assign free     = CW'(DEPTH) - count;
  assign go_clear = idle && bus.clr_req;

  assign bus.upd0_ready = idle && (free >= CW'(1));
  assign bus.upd1_ready = idle && (free >= CW'(2));
  assign bus.fl_ready   = idle && !slot_vld;
  assign bus.clr_busy   = !idle;

  // Requests taken on the clear edge are dropped with the rest of the backlog.
  assign acc0   = bus.upd0_valid && bus.upd0_ready && !go_clear;
  assign acc1   = bus.upd1_valid && bus.upd1_ready && !go_clear;
  assign acc_fl = bus.fl_valid && bus.fl_ready && !go_clear;

  assign in0 = '{addr: bus.upd0_addr, target: bus.upd0_target, flags: bus.upd0_flags};
  assign in1 = '{addr: bus.upd1_addr, target: bus.upd1_target, flags: bus.upd1_flags};

  assign conflict   = slot_vld && idx_match(head.addr, slot_addr, IDX_BITS);
  assign issue_corr = idle && !bus.clr_req && (count != '0) && !conflict;

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (go_clear),
    .wr0_en   (acc0),
    .wr0_data (in0),
    .wr1_en   (acc1),
    .wr1_data (in1),
    .rd_en    (issue_corr),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state                     <= BTBS_IDLE;
      cnt                       <= '0;
      slot_vld                  <= 1'b0;
      slot_addr                 <= '0;
      bus.corr_valid            <= 1'b0;
      bus.corr_addr             <= '0;
      bus.corr_branch_addr      <= '0;
      bus.corr_uncondition_flag <= 1'b0;
      bus.corr_link_flag        <= 1'b0;
      bus.corr_return_flag      <= 1'b0;
      bus.corr_fllush_valid     <= 1'b0;
      bus.corr_fllush_addr      <= '0;
    end else begin
      bus.corr_valid        <= 1'b0;
      bus.corr_fllush_valid <= 1'b0;
      case (state)
        BTBS_IDLE: begin
          if (bus.clr_req) begin
            state    <= BTBS_CLEAR;
            cnt      <= '0;
            slot_vld <= 1'b0;
          end else begin
            if (slot_vld) begin
              bus.corr_fllush_valid <= 1'b1;
              bus.corr_fllush_addr  <= slot_addr;
            end
            if (issue_corr) begin
              bus.corr_valid       <= 1'b1;
              bus.corr_addr        <= head.addr;
              bus.corr_branch_addr <= head.target;
              {bus.corr_uncondition_flag, bus.corr_link_flag, bus.corr_return_flag} <= head.flags;
            end
            // The occupied slot always issues this cycle, so it only stays full on a new load.
            slot_vld <= acc_fl;
            if (acc_fl) slot_addr <= bus.fl_addr;
          end
        end
        BTBS_CLEAR: begin
          bus.corr_fllush_valid <= 1'b1;
          bus.corr_fllush_addr  <= 32'({cnt, 2'b00});
          cnt                   <= cnt + 1'b1;
          if (&cnt) state <= BTBS_IDLE;
        end
        default: state <= BTBS_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_btb_upd_sched.sv
// Checks btb_upd_sched against a queue-based reference model every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_btb_upd_sched;
  localparam int DEPTH = 4;
  localparam int IB    = 4;
  localparam int NIDX  = 16;

  typedef struct {
    logic [31:0] a;
    logic [31:0] t;
    logic [2:0]  f;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  btb_upd_sched_if bus();

  btb_upd_sched #(.IDX_BITS(IB), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  ent_t        m_q[$];
  bit          m_slot_v = 0;
  logic [31:0] m_slot_a = '0;
  bit          m_clr = 0;
  int          m_cnt = 0;
  logic        e_cv = 0, e_fv = 0;
  logic [31:0] e_ca = '0, e_ct = '0, e_fa = '0;
  logic [2:0]  e_cf = '0;

  function automatic int idx(input logic [31:0] a);
    return int'((a / 32'd4) % NIDX);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int   free;
    bit   had;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_slot_v = 0; m_slot_a = '0; m_clr = 0; m_cnt = 0;
      e_cv = 0; e_ca = '0; e_ct = '0; e_cf = '0; e_fv = 0; e_fa = '0;
    end else if (m_clr) begin
      e_cv  = 0;
      e_fv  = 1;
      e_fa  = 32'(m_cnt * 4);
      m_cnt = m_cnt + 1;
      if (m_cnt == NIDX) begin
        m_clr = 0;
        m_cnt = 0;
      end
    end else if (bus.clr_req) begin
      m_clr = 1; m_cnt = 0; m_q.delete(); m_slot_v = 0;
      e_cv = 0; e_fv = 0;
    end else begin
      free = DEPTH - m_q.size();
      e_fv = m_slot_v;
      if (m_slot_v) e_fa = m_slot_a;
      e_cv = 0;
      if (m_q.size() > 0 && !(m_slot_v && idx(m_q[0].a) == idx(m_slot_a))) begin
        e = m_q.pop_front();
        e_cv = 1; e_ca = e.a; e_ct = e.t; e_cf = e.f;
      end
      if (bus.upd0_valid && free >= 1) m_q.push_back('{bus.upd0_addr, bus.upd0_target, bus.upd0_flags});
      if (bus.upd1_valid && free >= 2) m_q.push_back('{bus.upd1_addr, bus.upd1_target, bus.upd1_flags});
      had = m_slot_v;
      m_slot_v = 0;
      if (bus.fl_valid && !had) begin
        m_slot_v = 1;
        m_slot_a = bus.fl_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("corr_valid", 32'(bus.corr_valid), 32'(e_cv));
      chk("corr_addr", bus.corr_addr, e_ca);
      chk("corr_branch_addr", bus.corr_branch_addr, e_ct);
      chk("corr_flags", 32'({bus.corr_uncondition_flag, bus.corr_link_flag, bus.corr_return_flag}), 32'(e_cf));
      chk("flush_valid", 32'(bus.corr_fllush_valid), 32'(e_fv));
      chk("flush_addr", bus.corr_fllush_addr, e_fa);
      chk("upd0_ready", 32'(bus.upd0_ready), 32'(!m_clr && (DEPTH - m_q.size()) >= 1));
      chk("upd1_ready", 32'(bus.upd1_ready), 32'(!m_clr && (DEPTH - m_q.size()) >= 2));
      chk("fl_ready", 32'(bus.fl_ready), 32'(!m_clr && !m_slot_v));
      chk("clr_busy", 32'(bus.clr_busy), 32'(m_clr));
      if (bus.corr_valid && bus.corr_fllush_valid)
        chk("same_index_issue", 32'(idx(bus.corr_addr) == idx(bus.corr_fllush_addr)), 32'd0);
    end
  end

  task automatic quiet();
    bus.upd0_valid = 0; bus.upd1_valid = 0; bus.fl_valid = 0; bus.clr_req = 0;
  endtask

  task automatic set_upd0(input logic [31:0] a, input logic [31:0] t, input logic [2:0] f);
    bus.upd0_valid = 1; bus.upd0_addr = a; bus.upd0_target = t; bus.upd0_flags = f;
  endtask

  task automatic set_upd1(input logic [31:0] a, input logic [31:0] t, input logic [2:0] f);
    bus.upd1_valid = 1; bus.upd1_addr = a; bus.upd1_target = t; bus.upd1_flags = f;
  endtask

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    quiet();
    bus.upd0_addr = '0; bus.upd0_target = '0; bus.upd0_flags = '0;
    bus.upd1_addr = '0; bus.upd1_target = '0; bus.upd1_flags = '0;
    bus.fl_addr = '0;
    rst = 1;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_corr_valid", 32'(bus.corr_valid), 32'd0);
    chk("rst_corr_addr", bus.corr_addr, 32'd0);
    chk("rst_flush_addr", bus.corr_fllush_addr, 32'd0);
    chk("rst_upd1_ready", 32'(bus.upd1_ready), 32'd1);
    rst = 0;

    // single update
    repeat (2) @(negedge clk);
    set_upd0(32'h1C, 32'h400, 3'b100);
    @(negedge clk); quiet();
    @(negedge clk);
    chk("single_valid", 32'(bus.corr_valid), 32'd1);
    chk("single_addr", bus.corr_addr, 32'h1C);
    chk("single_target", bus.corr_branch_addr, 32'h400);
    chk("single_uncond", 32'(bus.corr_uncondition_flag), 32'd1);
    chk("single_link", 32'(bus.corr_link_flag), 32'd0);
    @(negedge clk);
    chk("single_once", 32'(bus.corr_valid), 32'd0);

    // dual accept ordering
    set_upd0(32'h10, 32'h500, 3'b000);
    set_upd1(32'h20, 32'h600, 3'b010);
    @(negedge clk); quiet();
    @(negedge clk);
    chk("dual_first", bus.corr_addr, 32'h10);
    @(negedge clk);
    chk("dual_second", bus.corr_addr, 32'h20);
    chk("dual_second_v", 32'(bus.corr_valid), 32'd1);
    repeat (2) @(negedge clk);

    // three queued: upd0 may enter, upd1 may not
    set_upd0(32'h30, 32'h1, 3'b001);
    set_upd1(32'h34, 32'h2, 3'b001);
    @(negedge clk);
    set_upd0(32'h38, 32'h3, 3'b001);
    set_upd1(32'h3C, 32'h4, 3'b001);
    @(negedge clk);
    quiet();
    chk("q3_upd0_ready", 32'(bus.upd0_ready), 32'd1);
    chk("q3_upd1_ready", 32'(bus.upd1_ready), 32'd0);
    repeat (6) @(negedge clk);

    // conflict: same index held one cycle
    bus.fl_valid = 1; bus.fl_addr = 32'h44;
    set_upd0(32'h84, 32'h900, 3'b000);
    @(negedge clk); quiet();
    @(negedge clk);
    chk("conf_flush_v", 32'(bus.corr_fllush_valid), 32'd1);
    chk("conf_flush_a", bus.corr_fllush_addr, 32'h44);
    chk("conf_corr_v", 32'(bus.corr_valid), 32'd0);
    @(negedge clk);
    chk("conf_corr_late_v", 32'(bus.corr_valid), 32'd1);
    chk("conf_corr_late_a", bus.corr_addr, 32'h84);
    chk("conf_flush_done", 32'(bus.corr_fllush_valid), 32'd0);
    repeat (2) @(negedge clk);

    // no conflict: both together
    bus.fl_valid = 1; bus.fl_addr = 32'h44;
    set_upd0(32'h48, 32'h910, 3'b000);
    @(negedge clk); quiet();
    @(negedge clk);
    chk("noconf_flush_v", 32'(bus.corr_fllush_valid), 32'd1);
    chk("noconf_corr_v", 32'(bus.corr_valid), 32'd1);
    chk("noconf_corr_a", bus.corr_addr, 32'h48);
    repeat (2) @(negedge clk);

    // clear with two queued updates
    set_upd0(32'h100, 32'hA, 3'b000);
    set_upd1(32'h104, 32'hB, 3'b000);
    @(negedge clk);
    quiet(); bus.clr_req = 1;
    @(negedge clk);
    bus.clr_req = 0;
    chk("clr_busy_start", 32'(bus.clr_busy), 32'd1);
    chk("clr_no_flush_yet", 32'(bus.corr_fllush_valid), 32'd0);
    chk("clr_no_corr_yet", 32'(bus.corr_valid), 32'd0);
    for (int i = 0; i < NIDX; i++) begin
      @(negedge clk);
      chk("clr_flush_v", 32'(bus.corr_fllush_valid), 32'd1);
      chk("clr_flush_a", bus.corr_fllush_addr, 32'(i * 4));
      chk("clr_corr_v", 32'(bus.corr_valid), 32'd0);
      chk("clr_busy", 32'(bus.clr_busy), 32'(i < NIDX - 1));
      chk("clr_upd0_ready", 32'(bus.upd0_ready), 32'(i == NIDX - 1));
    end
    @(negedge clk);
    chk("clr_after_flush_v", 32'(bus.corr_fllush_valid), 32'd0);
    chk("clr_queue_dropped", 32'(bus.corr_valid), 32'd0);
    @(negedge clk);
    chk("clr_queue_dropped2", 32'(bus.corr_valid), 32'd0);

    // reset during clear at index 5
    bus.clr_req = 1;
    @(negedge clk);
    bus.clr_req = 0;
    for (int i = 0; i <= 5; i++) @(negedge clk);
    chk("abort_at_idx5", bus.corr_fllush_addr, 32'h14);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_flush_v", 32'(bus.corr_fllush_valid), 32'd0);
    chk("abort_flush_a", bus.corr_fllush_addr, 32'd0);
    chk("abort_busy", 32'(bus.clr_busy), 32'd0);
    chk("abort_upd0_ready", 32'(bus.upd0_ready), 32'd1);
    chk("abort_fl_ready", 32'(bus.fl_ready), 32'd1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 499) == 0);
      bus.upd0_valid = ($urandom_range(0, 1) == 1);
      bus.upd1_valid = ($urandom_range(0, 9) < 4);
      bus.fl_valid   = ($urandom_range(0, 9) < 3);
      bus.clr_req    = ($urandom_range(0, 79) == 0);
      bus.upd0_addr  = rand_addr(); bus.upd0_target = $urandom; bus.upd0_flags = 3'($urandom_range(0, 7));
      bus.upd1_addr  = rand_addr(); bus.upd1_target = $urandom; bus.upd1_flags = 3'($urandom_range(0, 7));
      bus.fl_addr    = rand_addr();
    end
    @(negedge clk);
    rst = 0; quiet();
    repeat (24) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
